ram_dma: RTL
============

Name: ram_dma

Overview:
- Initiator-side block copy/fill engine that drives the single-port 64K x 8 system RAM (addr/data/we in, registered-address read q out).
- Moves a block of bytes from a source range to a destination range, or fills a range with a constant.
- Sits beside the CPU on the RAM port; an external mux grants the port while busy=1.
- Handles the RAM's one-cycle read latency: an address presented in cycle N returns data on q in cycle N+1.

Parameters:
- ADDR_W, 16, RAM address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- fill  in  1  sampled with start; 1 = fill mode, 0 = copy mode.
- src  in  ADDR_W  copy source base; sampled with start.
- dst  in  ADDR_W  destination base; sampled with start.
- len  in  ADDR_W  byte count, 0..65535; sampled with start.
- fill_val  in  DATA_W  fill byte; sampled with start.
- busy  out  1  high while in RD or WR.
- done  out  1  one-cycle pulse at completion.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data; valid the cycle after its address was driven.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_data=0, all internal pointers and counters 0.
- Reset mid-transfer: the engine aborts at the next edge. mem_we is 0 from the following cycle. Bytes already written stay written. done is not pulsed.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 latches src_ptr=src, dst_ptr=dst, cnt=len, mode=fill, val=fill_val.
  - Next state: FIN if len=0; WR if fill=1; otherwise RD.
  - start=0: stay in IDLE.
- RD (copy only): mem_addr=src_ptr, mem_we=0. Next state WR.
- WR:
  - mem_addr=dst_ptr, mem_we=1.
  - mem_data = mem_q in copy mode (this is the data from the previous RD cycle), or val in fill mode.
  - On the edge: dst_ptr+1, src_ptr+1, cnt-1.
  - If cnt=1 before the decrement, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill).
- FIN: done=1, busy=0, mem_we=0. Next state IDLE.
- Outputs in IDLE and FIN: mem_we=0, mem_addr=0, mem_data=0.
- busy is 1 in RD and WR only.
- Latency:
  - Copy of N>0 bytes: busy for 2N cycles, done on cycle 2N+1 after the start edge.
  - Fill of N>0 bytes: busy for N cycles, done on cycle N+1.
  - len=0: done on the cycle after start, with no RAM activity.
- Repeat requests: start is ignored when not in IDLE, including in FIN. A new start is accepted in the IDLE cycle that follows FIN.
- Wrap-around: pointers wrap 0xFFFF -> 0x0000 silently.
- len=0 means 0 bytes, not 65536.
- Overlap: copy always proceeds in ascending address order.
  - dst > src with overlapping ranges propagates already-written bytes (defined behaviour, not an error).
  - dst == src rewrites identical data.
- mem_data in copy mode is a combinational pass-through of mem_q. No other combinational path runs from inputs to outputs; outputs depend only on state and registered values.

Decomposition:
- Shared package ram_dma_pkg holds:
  - the state enum (IDLE, RD, WR, FIN);
  - ADDR_W/DATA_W defaults;
  - the RAM read latency constant RD_LAT=1.
- No sub-module. Pointers, counter and FSM sit in one module; one RAM model instance is used in the bench only.

Test Plan:
- Copy: preload RAM[0x1000..0x1003]=11,22,33,44; start copy src=0x1000 dst=0x2000 len=4. Required: RAM[0x2000..0x2003]=11,22,33,44; busy high for exactly 8 cycles; done pulses once on cycle 9; mem_we high on alternate cycles only.
- Fill: fill dst=0x0100 len=3 fill_val=0xA5. Required: RAM[0x0100..0x0102]=A5; RAM[0x0103] unchanged; busy for 3 cycles; done on cycle 4.
- Zero length: len=0 in copy mode. Required: mem_we never asserted; done on the cycle after start; busy never 1.
- Wrap: fill dst=0xFFFE len=4 val=0x5A. Required: writes to FFFE, FFFF, 0000, 0001 in that order; RAM[0x0002] untouched.
- Overlap and start-ignore: preload RAM[0x10]=7, RAM[0x11]=8; copy src=0x10 dst=0x11 len=2; pulse start again mid-transfer. Required: RAM[0x11]=7, RAM[0x12]=7; the second start has no effect; exactly one done pulse.
- Reset mid-op: copy len=10; assert rst on the 5th busy cycle. Required: busy=0 and mem_we=0 on the next cycle; no done pulse; a subsequent len=1 copy completes normally.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM block copy/fill engine.
package ram_dma_pkg;

  localparam int unsigned ADDR_W_DFLT = 16;
  localparam int unsigned DATA_W_DFLT = 8;

  // Cycles from driving mem_addr to valid mem_q; the RD->WR pairing assumes 1.
  localparam int unsigned RD_LAT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StFin
  } state_e;

endpackage

// File: rtl/ram_dma.sv
// Block copy/fill engine driving a single-port RAM with one-cycle registered read.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] val_q, val_d;

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    val_d     = val_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_ptr_d = src;
          dst_ptr_d = dst;
          cnt_d     = len;
          mode_d    = fill;
          val_d     = fill_val;
          if (len == '0) begin
            state_d = StFin;
          end else if (fill) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        state_d = StWr;
      end
      StWr: begin
        // Pointers wrap modulo 2^ADDR_W; ascending order makes overlapping copies propagate.
        src_ptr_d = src_ptr_q + ADDR_W'(1);
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        cnt_d     = cnt_q - ADDR_W'(1);
        if (cnt_q == ADDR_W'(1)) begin
          state_d = StFin;
        end else if (mode_q) begin
          state_d = StWr;
        end else begin
          state_d = StRd;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      val_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      val_q     <= val_d;
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_we   = 1'b0;
    unique case (state_q)
      StRd: begin
        busy     = 1'b1;
        mem_addr = src_ptr_q;
      end
      StWr: begin
        busy     = 1'b1;
        mem_addr = dst_ptr_q;
        mem_we   = 1'b1;
        // Copy data is the byte read during the preceding RD cycle.
        mem_data = mode_q ? val_q : mem_q;
      end
      StFin: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
